sprite_compositor: RTL

// - Consumer end of the 16x16 sprite bitmap ROMs: scans the VGA pixel stream, computes

---
 rtl/sprite_compositor.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sprite_compositor.sv
// Maps the scan position onto player/platform sprite ROM coordinates and registers a per-pixel layer select.
// One cycle of latency, one pixel per clock, never stalls; overlap totals are reported at each frame start.
module sprite_compositor #(
    parameter int SIZE  = 16,
    parameter int HIT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    input  logic [9:0]       player_x,
    input  logic [9:0]       player_y,
    input  logic [9:0]       plat_x,
    input  logic [9:0]       plat_y,
    output logic [9:0]       player_rom_x,
    output logic [9:0]       player_rom_y,
    input  logic             player_rom_bit,
    output logic [9:0]       plat_rom_x,
    output logic [9:0]       plat_rom_y,
    input  logic             plat_rom_bit,
    output logic             pix_out_valid,
    output logic [1:0]       pix_sel,
    output logic             collision,
    output logic [HIT_W-1:0] hit_count
);
    typedef enum logic {WAIT_FRAME, ACTIVE} state_t;

    localparam logic [10:0]      SZ      = 11'(SIZE);
    localparam logic [HIT_W-1:0] HIT_MAX = '1;

    state_t           state, state_nxt;
    logic             run;
    logic [9:0]       sh_px, sh_py, sh_fx, sh_fy;
    logic [9:0]       ox_p, oy_p, ox_f, oy_f;
    logic             in_p, in_f, hit_p, hit_f;
    logic             ovl1, coll_acc;
    logic [HIT_W-1:0] hit_acc, hit_sum;

    function automatic logic in_span(input logic [9:0] d, input logic [9:0] o);
        return ({1'b0, d} >= {1'b0, o}) && ({1'b0, d} < ({1'b0, o} + SZ));
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= WAIT_FRAME;
        else       state <= state_nxt;
    end

    // The frame_start cycle already belongs to the new frame, so it runs as ACTIVE.
    always_comb begin
        state_nxt = state;
        run       = (state == ACTIVE);
        if (frame_start) begin
            state_nxt = ACTIVE;
            run       = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sh_px <= '0;
            sh_py <= '0;
            sh_fx <= '0;
            sh_fy <= '0;
        end else if (frame_start) begin
            sh_px <= player_x;
            sh_py <= player_y;
            sh_fx <= plat_x;
            sh_fy <= plat_y;
        end
    end

    // A pixel coincident with frame_start sees the origins being latched.
    assign ox_p = frame_start ? player_x : sh_px;
    assign oy_p = frame_start ? player_y : sh_py;
    assign ox_f = frame_start ? plat_x   : sh_fx;
    assign oy_f = frame_start ? plat_y   : sh_fy;

    assign in_p = in_span(DrawX, ox_p) && in_span(DrawY, oy_p);
    assign in_f = in_span(DrawX, ox_f) && in_span(DrawY, oy_f);

    assign player_rom_x = in_p ? (DrawX - ox_p) : 10'h3FF;
    assign player_rom_y = in_p ? (DrawY - oy_p) : 10'h3FF;
    assign plat_rom_x   = in_f ? (DrawX - ox_f) : 10'h3FF;
    assign plat_rom_y   = in_f ? (DrawY - oy_f) : 10'h3FF;

    assign hit_p = player_rom_bit & in_p;
    assign hit_f = plat_rom_bit & in_f;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pix_out_valid <= 1'b0;
            pix_sel       <= 2'b00;
            ovl1          <= 1'b0;
        end else begin
            pix_out_valid <= pix_valid;
            ovl1          <= pix_valid & run & hit_p & hit_f;
            if (pix_valid && run)
                pix_sel <= hit_p ? 2'b10 : (hit_f ? 2'b01 : 2'b00);
            else
                pix_sel <= 2'b00;
        end
    end

    assign hit_sum = (hit_acc == HIT_MAX) ? HIT_MAX : (hit_acc + HIT_W'(ovl1));

    // The stage-1 pixel present at frame_start still closes the old frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            coll_acc  <= 1'b0;
            hit_acc   <= '0;
            collision <= 1'b0;
            hit_count <= '0;
        end else if (frame_start) begin
            collision <= coll_acc | ovl1;
            hit_count <= hit_sum;
            coll_acc  <= 1'b0;
            hit_acc   <= '0;
        end else if (state == ACTIVE) begin
            coll_acc <= coll_acc | ovl1;
            hit_acc  <= hit_sum;
        end
    end
endmodule
